// File: rtl/stream_minmax_avg.sv
// Running max/min tracker with a DEPTH-tap delay line, window sum/mean and a
// registered, selectable result. IDLE -> INIT -> RUN, CLEAR returns to INIT.
module stream_minmax_avg #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             restart_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             out_valid_o,
  output logic             warm_o,
  output logic [WIDTH-1:0] rmax_o,
  output logic [WIDTH-1:0] rmin_o
);

  // state | meaning
  // IDLE  | after reset, waits one edge
  // INIT  | loads RMAX/RMIN from DATA_IN, clears taps/sum/fill
  // RUN   | accepts samples, drives DATA_OUT
  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2} state_t;

  localparam int LG = $clog2(DEPTH);
  localparam int SW = WIDTH + LG;
  localparam int CW = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] rmax_q, rmax_d;
  logic [WIDTH-1:0] rmin_q, rmin_d;
  logic [WIDTH-1:0] rlast_q, rlast_d;
  logic [WIDTH-1:0] tap_q [DEPTH];
  logic [WIDTH-1:0] tap_d [DEPTH];
  logic [SW-1:0]    sum_q, sum_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             out_valid_q, out_valid_d;
  logic             warm_q, warm_d;

  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) < $signed(b);
    else        return a < b;
  endfunction

  // The (WIDTH+1)-bit sum cannot overflow; bits [WIDTH:1] are the floor average.
  function automatic logic [WIDTH-1:0] avg(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {(SIGNED ? a[WIDTH-1] : 1'b0), a} + {(SIGNED ? b[WIDTH-1] : 1'b0), b};
    return s[WIDTH:1];
  endfunction

  function automatic logic [SW-1:0] ext(input logic [WIDTH-1:0] a);
    logic [LG-1:0] hi;
    hi = (SIGNED && a[WIDTH-1]) ? {LG{1'b1}} : {LG{1'b0}};
    return {hi, a};
  endfunction

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    rmax_d      = rmax_q;
    rmin_d      = rmin_q;
    rlast_d     = rlast_q;
    tap_d       = tap_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    warm_d      = warm_q;

    case (state_q)
      IDLE: state_d = INIT;

      INIT: begin
        state_d     = RUN;
        rmax_d      = data_in_i;
        rmin_d      = data_in_i;
        rlast_d     = '0;
        for (int i = 0; i < DEPTH; i++) tap_d[i] = '0;
        sum_d       = '0;
        fill_d      = '0;
        data_out_d  = '0;
        out_valid_d = 1'b0;
        warm_d      = 1'b0;
      end

      RUN: begin
        if (clear_i) begin
          state_d     = INIT;
          data_out_d  = '0;
          out_valid_d = 1'b0;
          warm_d      = 1'b0;
        end else begin
          out_valid_d = 1'b1;
          if (restart_i) begin
            data_out_d = avg(rmax_q, rmin_q);
          end else if (enable_i) begin
            case (sel_i)
              2'd0:    data_out_d = tap_q[DEPTH-1];
              2'd1:    data_out_d = avg(data_in_i, tap_q[DEPTH-1]);
              2'd2:    data_out_d = sum_q[SW-1:LG];
              default: data_out_d = data_in_i;
            endcase
          end else begin
            data_out_d = rlast_q;
          end

          if (enable_i) begin
            rlast_d  = data_in_i;
            tap_d[0] = data_in_i;
            for (int i = 1; i < DEPTH; i++) tap_d[i] = tap_q[i-1];
            sum_d    = sum_q + ext(data_in_i) - ext(tap_q[DEPTH-1]);
            if (fill_q != CW'(DEPTH)) fill_d = fill_q + CW'(1);
            if (gt(data_in_i, rmax_q))      rmax_d = data_in_i;
            else if (lt(data_in_i, rmin_q)) rmin_d = data_in_i;
          end
          warm_d = (fill_d == CW'(DEPTH));
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      data_out_q  <= '0;
      rmax_q      <= '0;
      rmin_q      <= '0;
      rlast_q     <= '0;
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      warm_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      rmax_q      <= rmax_d;
      rmin_q      <= rmin_d;
      rlast_q     <= rlast_d;
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= tap_d[i];
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      warm_q      <= warm_d;
    end
  end

  assign data_out_o  = data_out_q;
  assign out_valid_o = out_valid_q;
  assign warm_o      = warm_q;
  assign rmax_o      = rmax_q;
  assign rmin_o      = rmin_q;

endmodule

// File: tb/tb_stream_minmax_avg.sv
// Directed bench: one signed and one unsigned instance share all inputs.
module tb_stream_minmax_avg;

  logic       clk = 1'b0;
  logic       rst_n, restart, enable, clear;
  logic [1:0] sel;
  logic [7:0] din;
  logic [7:0] dout_s, rmax_s, rmin_s, dout_u, rmax_u, rmin_u;
  logic       vld_s, warm_s, vld_u, warm_u;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  stream_minmax_avg #(.WIDTH(8), .DEPTH(4), .SIGNED(1'b1)) u_s (
    .clock_i(clk), .reset_n_i(rst_n), .restart_i(restart), .enable_i(enable),
    .clear_i(clear), .sel_i(sel), .data_in_i(din), .data_out_o(dout_s),
    .out_valid_o(vld_s), .warm_o(warm_s), .rmax_o(rmax_s), .rmin_o(rmin_s));

  stream_minmax_avg #(.WIDTH(8), .DEPTH(4), .SIGNED(1'b0)) u_u (
    .clock_i(clk), .reset_n_i(rst_n), .restart_i(restart), .enable_i(enable),
    .clear_i(clear), .sel_i(sel), .data_in_i(din), .data_out_o(dout_u),
    .out_valid_o(vld_u), .warm_o(warm_u), .rmax_o(rmax_u), .rmin_o(rmin_u));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; restart = 0; enable = 0; clear = 0; sel = 2'd0; din = 8'h00;
    #2;
    checks++;
    if ({dout_s, rmax_s, rmin_s, vld_s, warm_s} !== 26'd0) begin
      failures++;
      $display("FAIL reset_outputs got dout=%h rmax=%h rmin=%h vld=%b warm=%b want all 0",
               dout_s, rmax_s, rmin_s, vld_s, warm_s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    din = 8'h55;
    step();  // IDLE -> INIT
    checks++;
    if (vld_s !== 1'b0 || rmax_s !== 8'h00) begin
      failures++;
      $display("FAIL idle_edge got vld=%b rmax=%h want vld=0 rmax=00", vld_s, rmax_s);
    end
    din = 8'h10;
    step();  // INIT
    checks++;
    if (rmax_s !== 8'h10 || rmin_s !== 8'h10 || vld_s !== 1'b0 || dout_s !== 8'h00) begin
      failures++;
      $display("FAIL init_edge got rmax=%h rmin=%h vld=%b dout=%h want 10 10 0 00",
               rmax_s, rmin_s, vld_s, dout_s);
    end
    din = 8'h00;
    step();  // first RUN edge, enable=0
    checks++;
    if (vld_s !== 1'b1 || dout_s !== 8'h00 || vld_u !== 1'b1) begin
      failures++;
      $display("FAIL first_run got vld_s=%b vld_u=%b dout=%h want 1 1 00", vld_s, vld_u, dout_s);
    end
  endtask

  task automatic test_minmax();
    logic [7:0] smp [3] = '{8'h7F, 8'h80, 8'h05};
    enable = 1; sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      din = smp[i];
      step();
      checks++;
      if (dout_s !== smp[i]) begin
        failures++;
        $display("FAIL sel3_passthru[%0d] got %h want %h", i, dout_s, smp[i]);
      end
    end
    checks++;
    if (rmax_s !== 8'h7F || rmin_s !== 8'h80) begin
      failures++;
      $display("FAIL signed_minmax got rmax=%h rmin=%h want 7f 80", rmax_s, rmin_s);
    end
    checks++;
    if (rmax_u !== 8'h80 || rmin_u !== 8'h05) begin
      failures++;
      $display("FAIL unsigned_minmax got rmax=%h rmin=%h want 80 05", rmax_u, rmin_u);
    end
    enable = 0; restart = 1;
    step();
    restart = 0;
    checks++;
    if (dout_s !== 8'hFF) begin
      failures++;
      $display("FAIL signed_restart_avg got %h want ff", dout_s);
    end
    checks++;
    if (dout_u !== 8'h42) begin
      failures++;
      $display("FAIL unsigned_restart_avg got %h want 42", dout_u);
    end
  endtask

  task automatic do_clear(input logic [7:0] v);
    enable = 0; restart = 0; clear = 1;
    step();
    clear = 0;
    checks++;
    if (vld_s !== 1'b0 || dout_s !== 8'h00 || warm_s !== 1'b0) begin
      failures++;
      $display("FAIL clear_edge got vld=%b dout=%h warm=%b want 0 00 0", vld_s, dout_s, warm_s);
    end
    din = v;
    step();  // INIT
    checks++;
    if (rmax_s !== v || rmin_s !== v || rmax_u !== v || rmin_u !== v || vld_s !== 1'b0) begin
      failures++;
      $display("FAIL clear_init got rmax=%h rmin=%h rmax_u=%h rmin_u=%h vld=%b want %h and vld 0",
               rmax_s, rmin_s, rmax_u, rmin_u, vld_s, v);
    end
  endtask

  task automatic test_delay_line();
    logic [7:0] exp_d [6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd4};
    enable = 1;
    for (int i = 0; i < 6; i++) begin
      sel = (i == 5) ? 2'd1 : 2'd0;
      din = 8'(i + 1);
      step();
      checks++;
      if (dout_s !== exp_d[i] || dout_u !== exp_d[i]) begin
        failures++;
        $display("FAIL delay_line[%0d] got s=%0d u=%0d want %0d", i, dout_s, dout_u, exp_d[i]);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (warm_s !== (i == 3)) begin
          failures++;
          $display("FAIL delay_warm[%0d] got %b want %b", i, warm_s, (i == 3));
        end
      end
    end
    checks++;
    if (rmax_s !== 8'd6 || rmin_s !== 8'd0) begin
      failures++;
      $display("FAIL delay_minmax got rmax=%h rmin=%h want 06 00", rmax_s, rmin_s);
    end
  endtask

  task automatic test_window_mean();
    logic [7:0] smp [10] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'h00};
    logic [7:0] exp_m [10] = '{8'd0, 8'd1, 8'd3, 8'd6, 8'd10, 8'd14, 8'd11, 8'd7, 8'd2, 8'hFD};
    enable = 1; sel = 2'd2;
    for (int i = 0; i < 10; i++) begin
      din = smp[i];
      step();
      checks++;
      if (dout_s !== exp_m[i]) begin
        failures++;
        $display("FAIL mean[%0d] got %h want %h", i, dout_s, exp_m[i]);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (warm_s !== (i == 3) || warm_u !== (i == 3)) begin
          failures++;
          $display("FAIL mean_warm[%0d] got s=%b u=%b want %b", i, warm_s, warm_u, (i == 3));
        end
      end
    end
    checks++;
    if (dout_u !== 8'hFD) begin
      failures++;
      $display("FAIL unsigned_mean got %h want fd", dout_u);
    end
    checks++;
    if (rmax_s !== 8'h14 || rmin_s !== 8'hFD || rmax_u !== 8'hFD || rmin_u !== 8'h00) begin
      failures++;
      $display("FAIL mean_minmax got s=%h/%h u=%h/%h want 14/fd fd/00", rmax_s, rmin_s, rmax_u, rmin_u);
    end
  endtask

  task automatic test_hold();
    enable = 0; restart = 0; din = 8'h7F; sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dout_s !== 8'h00 || rmax_s !== 8'h14 || rmin_s !== 8'hFD || warm_s !== 1'b1) begin
        failures++;
        $display("FAIL hold[%0d] got dout=%h rmax=%h rmin=%h warm=%b want 00 14 fd 1",
                 i, dout_s, rmax_s, rmin_s, warm_s);
      end
    end
    enable = 1; restart = 1; din = 8'h40; sel = 2'd2;
    step();
    restart = 0;
    checks++;
    if (dout_s !== 8'h08 || dout_u !== 8'h7E) begin
      failures++;
      $display("FAIL restart_with_enable got s=%h u=%h want 08 7e", dout_s, dout_u);
    end
    checks++;
    if (rmax_s !== 8'h40 || rmax_u !== 8'hFD) begin
      failures++;
      $display("FAIL restart_rmax got s=%h u=%h want 40 fd", rmax_s, rmax_u);
    end
    enable = 0;
    step();
    checks++;
    if (dout_s !== 8'h40 || dout_u !== 8'h40) begin
      failures++;
      $display("FAIL restart_rlast got s=%h u=%h want 40 40", dout_s, dout_u);
    end
    enable = 1; din = 8'h00; sel = 2'd2;
    step();
    checks++;
    if (dout_s !== 8'h0E || dout_u !== 8'h8E) begin
      failures++;
      $display("FAIL held_sum got s=%h u=%h want 0e 8e", dout_s, dout_u);
    end
  endtask

  task automatic test_async_reset();
    enable = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout_s, rmax_s, rmin_s, vld_s, warm_s, dout_u, rmax_u, vld_u} !== 43'd0) begin
      failures++;
      $display("FAIL async_reset got dout=%h rmax=%h rmin=%h vld=%b warm=%b dout_u=%h want all 0",
               dout_s, rmax_s, rmin_s, vld_s, warm_s, dout_u);
    end
    #2;
    rst_n = 1'b1;
    din = 8'h33;
    step();  // IDLE -> INIT, DATA_IN ignored
    checks++;
    if (rmax_s !== 8'h00 || vld_s !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle got rmax=%h vld=%b want 00 0", rmax_s, vld_s);
    end
    step();  // INIT samples 0x33
    checks++;
    if (rmax_s !== 8'h33 || rmin_s !== 8'h33 || vld_s !== 1'b0) begin
      failures++;
      $display("FAIL rst_init got rmax=%h rmin=%h vld=%b want 33 33 0", rmax_s, rmin_s, vld_s);
    end
    step();
    checks++;
    if (vld_s !== 1'b1 || warm_s !== 1'b0) begin
      failures++;
      $display("FAIL rst_run got vld=%b warm=%b want 1 0", vld_s, warm_s);
    end
  endtask

  initial begin
    test_reset();
    test_minmax();
    do_clear(8'h00);
    test_delay_line();
    do_clear(8'h00);
    test_window_mean();
    test_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_minmax_avg.md
Name: stream_minmax_avg

Overview:
- Parametrised successor to the ITC99-style running min/max/average tracker.
- Accepts one WIDTH-bit sample per enabled cycle and tracks the running maximum and minimum.
- Keeps a DEPTH-tap sample delay line and a running window sum.
- Drives a registered DATA_OUT chosen by RESTART/ENABLE/SEL.
- Adds signed/unsigned mode, stall-on-disable, sync CLEAR, window mean and a warm-up flag.
- Sits between sample source and downstream filter stages.

Parameters:
WIDTH, 8, sample/data width (>=2)
DEPTH, 4, delay-line taps and window length (power of two, >=2)
SIGNED, 1, 1 = two's-complement compare/arithmetic, 0 = unsigned

Ports:
CLOCK  input  1  sole clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
RESTART  input  1  output avg(RMAX,RMIN) this cycle
ENABLE  input  1  sample accept strobe
CLEAR  input  1  synchronous return to INIT
SEL  input  2  output select when ENABLE and not RESTART
DATA_IN  input  WIDTH  sample
DATA_OUT  output  WIDTH  registered result
OUT_VALID  output  1  DATA_OUT meaningful (RUN state)
WARM  output  1  DEPTH samples accepted since INIT
RMAX_OUT  output  WIDTH  running maximum
RMIN_OUT  output  WIDTH  running minimum

Behaviour:
- States: IDLE -> INIT -> RUN. IDLE->INIT and INIT->RUN are unconditional, one edge each. RUN stays in RUN unless CLEAR=1, which moves to INIT.
- Async reset (RESET_N=0), including mid-run: state=IDLE. DATA_OUT, RMAX, RMIN, RLAST, all taps, SUM and fill count = 0. OUT_VALID=0, WARM=0. Takes effect immediately and overrides all other inputs.
- IDLE and INIT ignore RESTART, ENABLE and SEL. DATA_IN is sampled only by INIT.
- INIT edge:
  - RMAX = RMIN = DATA_IN.
  - Taps, SUM, RLAST, DATA_OUT and fill count = 0.
  - OUT_VALID=0, WARM=0.
- RUN edge with CLEAR=0. All right-hand values are pre-edge register values. Latency is one cycle.
- DATA_OUT priority:
  - RESTART=1: avg(RMAX,RMIN).
  - Else ENABLE=1:
    - SEL=0: TAP[DEPTH-1].
    - SEL=1: avg(DATA_IN, TAP[DEPTH-1]).
    - SEL=2: SUM >>> log2(DEPTH).
    - SEL=3: DATA_IN.
  - Else: RLAST.
- When ENABLE=1, regardless of RESTART:
  - RLAST = DATA_IN.
  - Taps shift: TAP[0] = DATA_IN, TAP[i] = TAP[i-1].
  - SUM = SUM + DATA_IN - TAP[DEPTH-1].
  - Fill count increments, saturating at DEPTH.
  - If DATA_IN > RMAX: RMAX = DATA_IN. Else if DATA_IN < RMIN: RMIN = DATA_IN.
- When ENABLE=0: taps, SUM, RLAST, RMAX, RMIN and fill count hold.
- OUT_VALID=1 after every RUN edge with CLEAR=0.
- CLEAR=1 in RUN: next state INIT. That edge zeroes DATA_OUT, OUT_VALID and WARM; other registers hold until the INIT edge.
- WARM = (fill count == DEPTH).
- Arithmetic:
  - avg(x,y) = floor((x+y)/2), computed in WIDTH+1 bits, then shifted right by 1. Sign-extend and arithmetic-shift when SIGNED=1; zero-extend and logical-shift when SIGNED=0. No overflow possible.
  - SUM is WIDTH+log2(DEPTH) bits, interpreted per SIGNED; the mean is floor division.
  - Comparisons are signed when SIGNED=1, unsigned otherwise.
  - Before WARM, SEL=2 uses zero-filled taps, so the result is biased toward 0.
- Invariant: RMIN <= RMAX (per SIGNED) in RUN.
- RMAX_OUT and RMIN_OUT are the RMAX and RMIN registers.

Test Plan (WIDTH=8, DEPTH=4, SIGNED=1 unless noted):
1. Startup:
   - Stimulus: RESET_N low then released; DATA_IN=0x10 at the second edge.
   - Response: IDLE, INIT, RUN; RMAX=RMIN=0x10; DATA_OUT=0x00; OUT_VALID=1 after the third edge.
2. Signed min/max:
   - Stimulus: ENABLE=1 with samples 0x7F, 0x80, 0x05; then RESTART=1.
   - Response: RMAX=0x7F, RMIN=0x80; DATA_OUT=0xFF (floor(-0.5)).
   - Repeat with SIGNED=0: RMAX=0x80, RMIN=0x05; RESTART gives 0x42.
3. Delay line:
   - Stimulus: SEL=0, ENABLE=1, samples 1,2,3,4,5,6.
   - Response: DATA_OUT = 0,0,0,0,1,2.
   - With SEL=1 on sample 6: avg(6,2)=4.
4. Window mean:
   - Stimulus: SEL=2, samples 4,8,12,16, then 20.
   - Response: WARM=1 after the 4th edge; DATA_OUT=10 on the 5th edge.
   - Samples -3,-3,-3,-3, then any: DATA_OUT=0xFD.
5. Hold:
   - Stimulus: ENABLE=0, DATA_IN=0x7F, RESTART=0 for 3 cycles.
   - Response: DATA_OUT=RLAST; taps, SUM, RMAX, RMIN and WARM unchanged.
   - RESTART=1 with ENABLE=1: DATA_OUT=avg(old RMAX,RMIN); RLAST and taps still update.
6. Clear and mid-run reset:
   - CLEAR=1 in RUN: OUT_VALID=0 and DATA_OUT=0 next edge. INIT loads RMAX=RMIN=DATA_IN and clears WARM and taps.
   - RESET_N pulse between edges: all outputs 0 immediately; sequence restarts from IDLE.
